// File: rtl/mem_access_pkg.sv
// Shared state type and constants for the load/store access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int WORD_SHIFT = 3;
    localparam int WAIT_W     = 4;

endpackage

// File: rtl/mem_addr_check.sv
// Effective-address computation with alignment and range fault detection.
module mem_addr_check
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic [63:0] base,
    input  logic [8:0]  offset,
    output logic [63:0] index,
    output logic        fault
);

    logic [63:0] ea;

    // ea wraps modulo 2^64, so a negative offset below zero lands far out of range
    always_comb begin
        ea    = base + {{55{offset[8]}}, offset};
        index = ea >> WORD_SHIFT;
        fault = (ea[WORD_SHIFT-1:0] != '0) || (index >= 64'(DEPTH));
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: accepts one request, strobes the data memory, and
// returns load data or a fault over a valid/ready response channel.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_base,
    input  logic [8:0]  req_offset,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] mem_adr,
    output logic [63:0] mem_datain,
    output logic        mem_w,
    output logic        mem_r,
    input  logic [63:0] mem_dataout
);

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic              is_write;
    logic [63:0]       index;
    logic              fault;

    mem_addr_check #(.DEPTH(DEPTH)) u_check (
        .base   (req_base),
        .offset (req_offset),
        .index  (index),
        .fault  (fault)
    );

    // mem_adr/mem_datain double as the latched request fields while in ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_write   <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            mem_adr    <= '0;
            mem_datain <= '0;
            mem_w      <= 1'b0;
            mem_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        if (fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            state      <= ACCESS;
                            is_write   <= req_write;
                            cnt        <= WAIT_W'(WAIT_CYCLES);
                            mem_adr    <= index;
                            mem_datain <= req_write ? req_wdata : '0;
                            mem_w      <= req_write;
                            mem_r      <= !req_write;
                            resp_fault <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (!is_write && cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!is_write) begin
                            resp_rdata <= mem_dataout;
                        end
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        mem_adr    <= '0;
                        mem_datain <= '0;
                        mem_w      <= 1'b0;
                        mem_r      <= 1'b0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_fault <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random transactions against a memory model.
module tb_mem_access_unit;

    localparam int DEPTH = 256;
    localparam int W     = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, resp_ready;
    logic [63:0] req_base, req_wdata;
    logic [8:0]  req_offset;

    logic        req_ready, resp_valid, resp_fault, mem_w, mem_r;
    logic [63:0] resp_rdata, mem_adr, mem_datain, mem_dataout;
    logic        req_ready0, resp_valid0, resp_fault0, mem_w0, mem_r0;
    logic [63:0] resp_rdata0, mem_adr0, mem_datain0, mem_dataout0;

    int total = 0;
    int bad   = 0;

    bit [63:0]   mem     [DEPTH];
    bit          written [DEPTH];
    logic [63:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    mem_access_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_adr(mem_adr),
        .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
        .mem_dataout(mem_dataout)
    );

    mem_access_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_write(req_write), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata0), .resp_fault(resp_fault0), .mem_adr(mem_adr0),
        .mem_datain(mem_datain0), .mem_w(mem_w0), .mem_r(mem_r0),
        .mem_dataout(mem_dataout0)
    );

    // Data memory: unwritten word i reads as i; writes on any posedge with mem_w high
    always @(posedge clk) begin
        if (mem_w) begin
            mem[mem_adr[7:0]]     <= mem_datain;
            written[mem_adr[7:0]] <= 1'b1;
        end
    end

    assign mem_dataout  = (mem_adr < DEPTH) ?
                          (written[mem_adr[7:0]] ? mem[mem_adr[7:0]] : 64'(mem_adr[7:0])) : '0;
    assign mem_dataout0 = (mem_adr0 < DEPTH) ?
                          (written[mem_adr0[7:0]] ? mem[mem_adr0[7:0]] : 64'(mem_adr0[7:0])) : '0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: handshake, strobe/latency observation, response, optional backpressure
    task automatic applyStimulus(input logic wr, input logic [63:0] base, input logic [8:0] off,
                                 input logic [63:0] wdata, input int hold);
        longint      soff;
        logic [63:0] ea, idx, exp_rdata, seen_adr, seen_adr0, seen_data;
        logic        exp_fault, both, ready_seen;
        int          lat, wcnt, rcnt, rcnt0, first;
        soff      = $signed(off);
        ea        = base + soff;
        idx       = ea / 8;
        exp_fault = (ea % 8 != 0) || (idx >= DEPTH);
        exp_rdata = (!wr && !exp_fault) ? ref_mem[idx[7:0]] : 64'd0;
        if (wr && !exp_fault) ref_mem[idx[7:0]] = wdata;

        @(negedge clk);
        checkOutput("req_ready_idle", {63'd0, req_ready}, 64'd1);
        checkOutput("req_ready0_idle", {63'd0, req_ready0}, 64'd1);
        req_valid = 1'b1; req_write = wr; req_base = base; req_offset = off; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_write = ~wr; req_base = {$urandom, $urandom};
        req_offset = 9'($urandom); req_wdata = {$urandom, $urandom};

        lat = 0; wcnt = 0; rcnt = 0; rcnt0 = 0; first = 0; both = 1'b0; ready_seen = 1'b0;
        seen_adr = '0; seen_adr0 = '0; seen_data = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (mem_w) begin wcnt++; seen_adr = mem_adr; seen_data = mem_datain; if (first == 0) first = cyc; end
            if (mem_r) begin rcnt++; seen_adr = mem_adr; if (first == 0) first = cyc; end
            if (mem_r0 || mem_w0) seen_adr0 = mem_adr0;
            if (mem_r0) rcnt0++;
            if ((mem_w && mem_r) || (mem_w0 && mem_r0)) both = 1'b1;
            if (req_ready) ready_seen = 1'b1;
            if (resp_valid) begin lat = cyc; break; end
            @(negedge clk);
        end

        checkOutput("latency", 64'(lat), exp_fault ? 64'd1 : (wr ? 64'd2 : 64'(2 + W)));
        checkOutput("mem_w_cycles", 64'(wcnt), (wr && !exp_fault) ? 64'd1 : 64'd0);
        checkOutput("mem_r_cycles", 64'(rcnt), (!wr && !exp_fault) ? 64'(1 + W) : 64'd0);
        checkOutput("mem_r0_cycles", 64'(rcnt0), (!wr && !exp_fault) ? 64'd1 : 64'd0);
        checkOutput("strobe_overlap", {63'd0, both}, 64'd0);
        checkOutput("ready_low_busy", {63'd0, ready_seen}, 64'd0);
        if (!exp_fault) begin
            checkOutput("strobe_start", 64'(first), 64'd1);
            checkOutput("mem_adr", seen_adr, idx);
            checkOutput("mem_adr0", seen_adr0, idx);
            if (wr) checkOutput("mem_datain", seen_data, wdata);
        end
        checkOutput("resp_fault", {63'd0, resp_fault}, {63'd0, exp_fault});
        checkOutput("resp_rdata", resp_rdata, exp_rdata);
        checkOutput("resp_fault0", {63'd0, resp_fault0}, {63'd0, exp_fault});
        checkOutput("resp_rdata0", resp_rdata0, exp_rdata);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_valid", {63'd0, resp_valid}, 64'd1);
            checkOutput("hold_rdata", resp_rdata, exp_rdata);
            checkOutput("hold_fault", {63'd0, resp_fault}, {63'd0, exp_fault});
            checkOutput("hold_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("accept_valid", {63'd0, resp_valid}, 64'd0);
        checkOutput("accept_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'(i);
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_base = '0;
        req_offset = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd0);
        checkOutput("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        checkOutput("rst_strobes", {62'd0, mem_w, mem_r}, 64'd0);
        checkOutput("rst_mem_adr", mem_adr, 64'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
        rst = 1'b0;

        $display("[TB] directed transactions");
        applyStimulus(1'b1, 64'h40, 9'd8, 64'hDEADBEEF, 0);
        applyStimulus(1'b0, 64'h10, 9'd0, 64'd0, 0);
        applyStimulus(1'b0, 64'h48, 9'd0, 64'd0, 0);
        applyStimulus(1'b0, 64'h43, 9'd0, 64'd0, 0);
        applyStimulus(1'b1, 64'h800, 9'd0, 64'h1234, 0);
        applyStimulus(1'b0, 64'h10, 9'h1E8, 64'd0, 0);
        applyStimulus(1'b0, 64'h7F8, 9'd0, 64'd0, 5);
        applyStimulus(1'b0, 64'h820, 9'h1E0, 64'd0, 0);

        $display("[TB] reset during load wait cycle");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_base = 64'h18; req_offset = 9'd0;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rl_mem_r_t1", {63'd0, mem_r}, 64'd1);
        checkOutput("rl_mem_r0_t1", {63'd0, mem_r0}, 64'd1);
        @(negedge clk);
        checkOutput("rl_mem_r_t2", {63'd0, mem_r}, 64'd1);
        checkOutput("rl_mem_r0_t2", {63'd0, mem_r0}, 64'd0);
        checkOutput("rl_valid0_t2", {63'd0, resp_valid0}, 64'd1);
        checkOutput("rl_rdata0_t2", resp_rdata0, 64'd3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rl_mem_r_after", {63'd0, mem_r}, 64'd0);
        checkOutput("rl_valid_after", {63'd0, resp_valid}, 64'd0);
        checkOutput("rl_valid0_after", {63'd0, resp_valid0}, 64'd0);
        checkOutput("rl_ready_in_rst", {63'd0, req_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rl_ready_after", {63'd0, req_ready}, 64'd1);
        checkOutput("rl_valid_idle", {63'd0, resp_valid}, 64'd0);

        $display("[TB] reset coinciding with store strobe");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_base = 64'h100; req_offset = 9'd0;
        req_wdata = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rs_mem_w", {63'd0, mem_w}, 64'd1);
        rst = 1'b1;
        ref_mem[32] = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rs_mem_w_after", {63'd0, mem_w}, 64'd0);
        checkOutput("rs_valid_after", {63'd0, resp_valid}, 64'd0);
        applyStimulus(1'b0, 64'h100, 9'd0, 64'd0, 1);

        $display("[TB] random transactions");
        for (int n = 0; n < 40; n++) begin
            int          kind, idx, k;
            logic [8:0]  off;
            logic [63:0] base;
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, DEPTH - 1);
            k    = $urandom_range(0, 63);
            off  = 9'((k - 32) * 8);
            base = 64'(idx * 8) - 64'((k - 32) * 8);
            if (kind == 0) base = base + 64'($urandom_range(1, 7));
            else if (kind == 1) base = base + 64'(DEPTH * 8 + $urandom_range(0, 4000) * 8);
            applyStimulus(1'($urandom_range(0, 1)), base, off, {$urandom, $urandom},
                          $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
